gray_to_bin_seq: RTL and testbench

GRAY_TO_BIN_SEQ -- requirements
Module: gray_to_bin_seq

---
 rtl/gray_pkg.sv | 10 +
 rtl/gray_adj_check.sv | 16 +
 rtl/gray_to_bin_seq.sv | 84 ++++++++
 tb/tb_gray_to_bin_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and defaults for the sequential Gray-to-binary decoder.
package gray_pkg;
  localparam int GRAY_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_e;
endpackage

// File: rtl/gray_adj_check.sv
// Combinational adjacency check: the two words differ in exactly one bit.
module gray_adj_check #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             adjacent
);
  logic [WIDTH-1:0] diff;

  // popcount(diff) == 1 <=> diff is a nonzero power of two
  always_comb begin
    diff     = a ^ b;
    adjacent = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  end
endmodule

// File: rtl/gray_to_bin_seq.sv
// Bit-serial Gray-to-binary decoder, MSB first, with adjacency error tracking.
module gray_to_bin_seq
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gray,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_adj_err,
  input  logic             out_ready,
  output logic [CNT_W-1:0] err_count
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state, state_nxt;
  logic [WIDTH-1:0] gray_r, bin_r, prev_gray;
  logic [IW-1:0]    idx;
  logic             carry, adj_err_r, first_word;
  logic             adjacent, accept, flagged;

  gray_adj_check #(.WIDTH(WIDTH)) u_adj (
    .a        (in_gray),
    .b        (prev_gray),
    .adjacent (adjacent)
  );

  assign accept  = in_valid && in_ready;
  assign flagged = !first_word && !adjacent;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)      state_nxt = DECODE;
      DECODE:  if (idx == '0)     state_nxt = HOLD;
      HOLD:    if (out_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == HOLD);
    out_bin     = (state == HOLD) ? bin_r : '0;
    out_adj_err = (state == HOLD) && adj_err_r;
  end

  // carry holds the previously resolved binary bit (b[i+1]); starts at 0 so b[MSB] = g[MSB]
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_r     <= '0;
      bin_r      <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      adj_err_r  <= 1'b0;
      prev_gray  <= '0;
      first_word <= 1'b1;
      err_count  <= '0;
    end else if (accept) begin
      gray_r     <= in_gray;
      bin_r      <= '0;
      idx        <= IW'(WIDTH-1);
      carry      <= 1'b0;
      prev_gray  <= in_gray;
      first_word <= 1'b0;
      adj_err_r  <= flagged;
      if (flagged && (err_count != '1)) err_count <= err_count + CNT_W'(1);
    end else if (state == DECODE) begin
      bin_r[idx] <= carry ^ gray_r[idx];
      carry      <= carry ^ gray_r[idx];
      idx        <= idx - IW'(1);
    end
  end
endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Scoreboard bench for gray_to_bin_seq: expected results queued at accept, checked on output.
module tb_gray_to_bin_seq;
  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  typedef struct {
    logic [WIDTH-1:0] bin;
    logic             adj;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_gray = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_bin;
  logic             out_adj_err;
  logic             out_ready = 1'b1;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t             q[$];
  logic [WIDTH-1:0] m_prev;
  logic             m_first;
  logic [CNT_W-1:0] m_cnt;
  logic             ov_q = 1'b0;
  logic [WIDTH-1:0] held;

  gray_to_bin_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_gray     (in_gray),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_bin     (out_bin),
    .out_adj_err (out_adj_err),
    .out_ready   (out_ready),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // prefix-XOR form of the Gray decode
  function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b = '0;
    for (int s = 0; s < WIDTH; s++) b ^= (g >> s);
    return b;
  endfunction

  task automatic model_reset();
    q.delete();
    m_prev  = '0;
    m_first = 1'b1;
    m_cnt   = '0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic send(input logic [WIDTH-1:0] g);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin chk("wait_in_ready", 0, 1); return; end
    in_valid = 1'b1;
    in_gray  = g;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.adj = !m_first && ($countones(g ^ m_prev) != 1);
    if (e.adj && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    e.cnt   = m_cnt;
    e.bin   = g2b(g);
    e.cyc   = cyc;
    m_prev  = g;
    m_first = 1'b0;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (q.size() == 0) chk("spurious_valid", 1, 0);
      else begin
        if (!ov_q) begin
          chk("latency", cyc - q[0].cyc, WIDTH);
          held = out_bin;
        end else begin
          chk("hold_bin", out_bin, held);
          chk("hold_in_ready", in_ready, 0);
        end
        if (out_ready) begin
          e = q.pop_front();
          chk("out_bin", out_bin, e.bin);
          chk("out_adj_err", out_adj_err, e.adj);
          chk("err_count", err_count, e.cnt);
        end
      end
    end
    ov_q = out_valid;
  end

  initial begin
    int n;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_adj_err", out_adj_err, 0);
    chk("rst_err_count", err_count, 0);

    // adjacent walk from a first word
    send(4'b0110); send(4'b0111); send(4'b0101); send(4'b1101);
    drain();

    // two-bit jump then a repeat, both flagged
    pulse_reset();
    send(4'b0110); send(4'b0101); send(4'b0101);
    drain();

    // backpressure: hold for 10 cycles while upstream keeps offering
    out_ready = 1'b0;
    send(4'b0100);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("wait_out_valid", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_gray  = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // reset mid-decode discards the word; next word is a first word
    send(4'b0011);
    @(posedge clk); #1;
    pulse_reset();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_err_count", err_count, 0);
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_valid", out_valid, 0);
    end
    send(4'b1010);
    drain();

    // counter saturation
    pulse_reset();
    for (int i = 0; i < 6; i++) send(4'b0000);
    drain();
    chk("sat_err_count", err_count, 3);

    // exhaustive sweep in Gray order; expected binary is the loop index
    pulse_reset();
    for (int i = 0; i < 16; i++) begin
      logic [WIDTH-1:0] bi;
      bi = 4'(i);
      send(bi ^ (bi >> 1));
      chk("sweep_model", q[q.size()-1].bin, bi);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end
endmodule
